// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared pipelined 8x8 multiplier,
// with credit-based per-requester response FIFOs.
module mult_arbiter #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   input  logic        req0_sgnd,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   input  logic        req1_sgnd,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_p,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_p,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   output logic        mul_sgnd,
   input  logic [15:0] mul_p,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

   logic [LATENCY-1:0] tag_v;
   logic [LATENCY-1:0] tag_id;
   logic [CW-1:0]      infl [2];
   logic [CW-1:0]      cnt  [2];
   logic [AW-1:0]      wr   [2];
   logic [AW-1:0]      rd   [2];
   logic [15:0]        mem  [2][DEPTH];
   logic               ptr;

   logic [CW:0] use0, use1;
   logic        elig0, elig1;
   logic [1:0]  acc, wb, pop;

   // credits count both in-flight tags and buffered results
   assign use0  = {1'b0, infl[0]} + {1'b0, cnt[0]};
   assign use1  = {1'b0, infl[1]} + {1'b0, cnt[1]};
   assign elig0 = rst_n & (use0 < LIMIT);
   assign elig1 = rst_n & (use1 < LIMIT);

   assign req0_ready = elig0 & (~ptr | ~req1_valid | ~elig1);
   assign req1_ready = elig1 & (ptr | ~req0_valid | ~elig0);

   assign acc[0] = req0_valid & req0_ready;
   assign acc[1] = req1_valid & req1_ready;

   always_comb begin
      mul_a    = '0;
      mul_b    = '0;
      mul_sgnd = 1'b0;
      if (acc[0]) begin
         mul_a    = req0_a;
         mul_b    = req0_b;
         mul_sgnd = req0_sgnd;
      end else if (acc[1]) begin
         mul_a    = req1_a;
         mul_b    = req1_b;
         mul_sgnd = req1_sgnd;
      end
   end

   assign wb[0] = tag_v[LATENCY-1] & ~tag_id[LATENCY-1];
   assign wb[1] = tag_v[LATENCY-1] &  tag_id[LATENCY-1];

   assign rsp0_valid = (cnt[0] != '0);
   assign rsp1_valid = (cnt[1] != '0);
   assign rsp0_p     = rsp0_valid ? mem[0][rd[0]] : 16'h0000;
   assign rsp1_p     = rsp1_valid ? mem[1][rd[1]] : 16'h0000;
   assign pop[0]     = rsp0_valid & rsp0_ready;
   assign pop[1]     = rsp1_valid & rsp1_ready;

   assign busy = (|tag_v) | rsp0_valid | rsp1_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v  <= '0;
         tag_id <= '0;
         ptr    <= 1'b0;
      end else begin
         for (int i = LATENCY-1; i > 0; i--) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
         tag_v[0]  <= acc[0] | acc[1];
         tag_id[0] <= acc[1];
         if (acc[0])
            ptr <= 1'b1;
         else if (acc[1])
            ptr <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            infl[i] <= '0;
            cnt[i]  <= '0;
            wr[i]   <= '0;
            rd[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (acc[i] & ~wb[i])
               infl[i] <= infl[i] + 1'b1;
            else if (~acc[i] & wb[i])
               infl[i] <= infl[i] - 1'b1;
            if (wb[i] & ~pop[i])
               cnt[i] <= cnt[i] + 1'b1;
            else if (~wb[i] & pop[i])
               cnt[i] <= cnt[i] - 1'b1;
            if (wb[i])
               wr[i] <= wr[i] + 1'b1;
            if (pop[i])
               rd[i] <= rd[i] + 1'b1;
         end
      end
   end

   // storage needs no reset; validity comes from the counters
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (wb[i])
            mem[i][wr[i]] <= mul_p;
   end

endmodule
